csr_irq_unit: RTL and testbench
===============================

# csr_irq_unit

Parametrised machine-mode CSR and interrupt unit for the pipelined RV32 core, sitting beside the EXE stage. It holds the M-mode trap CSRs, 64-bit cycle/instret counters and a configurable bank of local interrupt lines. It arbitrates pending interrupts by fixed priority and produces the trap vector (direct or vectored), the MRET return target and the WFI stall.

## Interface
- NUM_LOCAL, 4, local interrupt lines, range 0..16; line i maps to mip/mie bit 16+i, cause 16+i
- MTVEC_RESET, 32'h0001_0000, mtvec reset value (MODE=direct)
- CNT_EN_RESET, 1'b1, counters run out of reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_req  in  1  EXE holds a CSR instruction this cycle
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101/110/111 immediate forms
- csr_addr  in  12  CSR address
- csr_src_zero  in  1  rs1 index / uimm is zero (suppresses RS/RC write)
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_rdata  out  32  old CSR value, combinational
- retire  in  1  one instruction retires this cycle
- mret  in  1  EXE holds MRET
- wfi  in  1  EXE holds WFI
- exe_pc  in  32  PC of EXE instruction
- irq_accept  in  1  pipeline can take a trap this cycle (EXE valid, not flushed)
- irq_ext  in  1  machine external interrupt, level
- irq_timer  in  1  machine timer interrupt, level
- irq_local  in  NUM_LOCAL  local interrupts, level
- trap_taken  out  1  redirect to trap_pc, flush EXE and younger
- trap_pc  out  32  handler address
- mret_pc  out  32  mepc
- wfi_stall  out  1  hold fetch/EXE

## Operation
- mstatus (0x300): MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11; other bits read 0.
- mie (0x304): writable bits 11, 7, 16..16+NUM_LOCAL-1; others 0.
- mip (0x344): read-only, bit11=irq_ext, bit7=irq_timer, bit16+i=irq_local[i]; writes ignored.
- mtvec (0x305): BASE[31:2] writable, MODE[1:0] 00 direct / 01 vectored; writes of MODE 1x store 00.
- mepc (0x341): bits[1:0] read 0. mcause (0x342): bit31 interrupt, [4:0] code.
- mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82) writable; 0xC00/0xC02/0xC80/0xC82 read-only shadows. mcountinhibit (0x320) bits 0 and 2 stop cycle/instret; reset value ~CNT_EN_RESET replicated.
- Unimplemented addresses: read 0, writes ignored.
- CSR write: RW new=wdata; RS new=old|wdata; RC new=old&~wdata; RS/RC with csr_src_zero do not write.
- pending = mip & mie. Priority: ext (11) > timer (7) > local highest index first.
- trap_taken = irq_accept & mstatus.MIE & |pending. On take: mepc<=exe_pc, mcause<={1,code}, MPIE<=MIE, MIE<=0; EXE instruction (CSR, MRET, WFI) is discarded.
- trap_pc: direct -> BASE<<2; vectored -> (BASE<<2)+4*code.
- mret (no trap): MIE<=MPIE, MPIE<=1. mret_pc = mepc.
- WFI: wfi_stall set next edge; cleared on edge after |pending=1 regardless of MIE. WFI with pending already nonzero: no stall.

## Timing
- csr_rdata, trap_taken, trap_pc, mret_pc combinational; state updates at next posedge.
- Reset: mstatus MIE=MPIE=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RESET, counters=0, wfi_stall=0, trap_taken=0.
- Counter: 64-bit, wraps 2^64-1 -> 0. Software write to a half replaces that half and suppresses that counter's increment this cycle; other half unchanged.
- minstret increments by 1 on retire; a retire coinciding with trap_taken still counts.
- Simultaneous trap + CSR write to mstatus/mepc/mcause: trap wins, write dropped.
- rst mid-WFI: stall drops on the reset edge.

## Test plan
- Reset, read every CSR -> mstatus=0x1800, mtvec=0x0001_0000, all others 0.
- CSRRS mie 0x880, CSRRSI mstatus 8, assert irq_timer with irq_accept, exe_pc=0x200 -> trap_taken=1, trap_pc=0x10000, then mepc=0x200, mcause=0x8000_0007, MIE=0, MPIE=1.
- mtvec=0x10001 (vectored), irq_ext and irq_timer and irq_local[2] together -> cause 11, trap_pc=0x1002C; MRET -> mret_pc=mepc, MIE=1.
- WFI with MIE=0, mie[16]=1; raise irq_local[0] 5 cycles later -> wfi_stall high 5 cycles, low next edge, trap_taken stays 0.
- Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF -> next cycle reads 0/0; mcountinhibit=1 -> mcycle frozen.
- CSRRC mstatus with rs1=x0 -> no change; CSRRW 0xC00 -> ignored, rdata returns mcycle.

Source files
------------

// File: rtl/csr_irq_unit_if.sv
// CSR access bus between the EXE stage and the M-mode CSR/interrupt unit.
// EXE drives the request; the unit returns the old CSR value combinationally.
interface csr_irq_unit_if;
  logic        csr_req;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic        csr_src_zero;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output csr_req, csr_op, csr_addr, csr_src_zero, csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_req, csr_op, csr_addr, csr_src_zero, csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/csr_irq_unit.sv
// Machine-mode trap CSRs, 64-bit counters and fixed-priority interrupt
// arbitration with direct/vectored trap vectoring, MRET and WFI stall.
module csr_irq_unit #(
  parameter int          NUM_LOCAL    = 4,
  parameter logic [31:0] MTVEC_RESET  = 32'h0001_0000,
  parameter logic        CNT_EN_RESET = 1'b1,
  localparam int         LW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
  input  logic           clk,
  input  logic           rst,
  csr_irq_unit_if.slave  csr,
  input  logic           retire,
  input  logic           mret,
  input  logic           wfi,
  input  logic [31:0]    exe_pc,
  input  logic           irq_accept,
  input  logic           irq_ext,
  input  logic           irq_timer,
  input  logic [LW-1:0]  irq_local,
  output logic           trap_taken,
  output logic [31:0]    trap_pc,
  output logic [31:0]    mret_pc,
  output logic           wfi_stall
);

  logic        st_mie;
  logic        st_mpie;
  logic [31:0] mie_q;
  logic [31:2] mepc_q;
  logic        mc_int;
  logic [4:0]  mc_code;
  logic [31:2] tv_base;
  logic        tv_vec;
  logic [63:0] cyc_q;
  logic [63:0] ins_q;
  logic        inh_cy;
  logic        inh_ir;

  logic [31:0] mie_mask;
  logic [31:0] mip;
  logic [31:0] pending;
  logic [4:0]  code;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        wr_en;

  logic unused_ok;
  assign unused_ok = ^{csr.csr_op[2], exe_pc[1:0]};

  always_comb begin
    mie_mask     = '0;
    mie_mask[11] = 1'b1;
    mie_mask[7]  = 1'b1;
    mip          = '0;
    mip[11]      = irq_ext;
    mip[7]       = irq_timer;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      mie_mask[16+i] = 1'b1;
      mip[16+i]      = irq_local[i];
    end
  end

  assign pending = mip & mie_q;

  // Later assignments win: ext over timer over higher-index locals.
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_LOCAL; i++)
      if (pending[16+i]) code = 5'(16 + i);
    if (pending[7])  code = 5'd7;
    if (pending[11]) code = 5'd11;
  end

  assign trap_taken = irq_accept & st_mie & (|pending);
  assign trap_pc    = tv_vec ? {tv_base, 2'b00} + {25'd0, code, 2'b00}
                             : {tv_base, 2'b00};
  assign mret_pc    = {mepc_q, 2'b00};

  always_comb begin
    unique case (csr.csr_addr)
      12'h300: old_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
      12'h304: old_val = mie_q;
      12'h344: old_val = mip;
      12'h305: old_val = {tv_base, 1'b0, tv_vec};
      12'h341: old_val = {mepc_q, 2'b00};
      12'h342: old_val = {mc_int, 26'd0, mc_code};
      12'h320: old_val = {29'd0, inh_ir, 1'b0, inh_cy};
      12'hB00, 12'hC00: old_val = cyc_q[31:0];
      12'hB80, 12'hC80: old_val = cyc_q[63:32];
      12'hB02, 12'hC02: old_val = ins_q[31:0];
      12'hB82, 12'hC82: old_val = ins_q[63:32];
      default: old_val = '0;
    endcase
  end

  assign csr.csr_rdata = old_val;

  always_comb begin
    unique case (1'b1)
      csr.csr_op[1:0] == 2'b01: new_val = csr.csr_wdata;
      csr.csr_op[1:0] == 2'b10: new_val = old_val | csr.csr_wdata;
      csr.csr_op[1:0] == 2'b11: new_val = old_val & ~csr.csr_wdata;
      default:                  new_val = old_val;
    endcase
  end

  // A taken trap discards the EXE instruction, so its CSR write is lost.
  assign wr_en = csr.csr_req & ~trap_taken & (csr.csr_op[1:0] != 2'b00)
               & ~(csr.csr_op[1] & csr.csr_src_zero);

  logic wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi;
  assign wr_cy_lo = wr_en & (csr.csr_addr == 12'hB00);
  assign wr_cy_hi = wr_en & (csr.csr_addr == 12'hB80);
  assign wr_ir_lo = wr_en & (csr.csr_addr == 12'hB02);
  assign wr_ir_hi = wr_en & (csr.csr_addr == 12'hB82);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie    <= 1'b0;
      st_mpie   <= 1'b0;
      mie_q     <= '0;
      mepc_q    <= '0;
      mc_int    <= 1'b0;
      mc_code   <= '0;
      tv_base   <= MTVEC_RESET[31:2];
      tv_vec    <= MTVEC_RESET[0] & ~MTVEC_RESET[1];
      inh_cy    <= ~CNT_EN_RESET;
      inh_ir    <= ~CNT_EN_RESET;
      wfi_stall <= 1'b0;
    end else begin
      if (trap_taken) begin
        mepc_q  <= exe_pc[31:2];
        mc_int  <= 1'b1;
        mc_code <= code;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end

      if (wr_en) begin
        unique case (csr.csr_addr)
          12'h300: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          12'h304: mie_q <= new_val & mie_mask;
          12'h305: begin
            tv_base <= new_val[31:2];
            tv_vec  <= new_val[0] & ~new_val[1];
          end
          12'h341: mepc_q <= new_val[31:2];
          12'h342: begin
            mc_int  <= new_val[31];
            mc_code <= new_val[4:0];
          end
          12'h320: begin
            inh_cy <= new_val[0];
            inh_ir <= new_val[2];
          end
          default: ;
        endcase
      end

      if (wfi_stall) begin
        if (|pending) wfi_stall <= 1'b0;
      end else if (wfi & ~trap_taken & ~(|pending)) begin
        wfi_stall <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (wr_cy_lo | wr_cy_hi) begin
        if (wr_cy_lo) cyc_q[31:0]  <= new_val;
        if (wr_cy_hi) cyc_q[63:32] <= new_val;
      end else if (!inh_cy) begin
        cyc_q <= cyc_q + 64'd1;
      end

      if (wr_ir_lo | wr_ir_hi) begin
        if (wr_ir_lo) ins_q[31:0]  <= new_val;
        if (wr_ir_hi) ins_q[63:32] <= new_val;
      end else if (!inh_ir && retire) begin
        ins_q <= ins_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed bench for csr_irq_unit: CSR reset values, traps, vectoring,
// MRET, WFI stall, counter wrap/inhibit and read-only/unimplemented CSRs.
module tb_csr_irq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire, mret, wfi, irq_accept, irq_ext, irq_timer;
  logic [31:0] exe_pc;
  logic [3:0]  irq_local;
  logic        trap_taken, wfi_stall;
  logic [31:0] trap_pc, mret_pc;

  int n_run  = 0;
  int n_fail = 0;

  csr_irq_unit_if bus ();

  csr_irq_unit #(
    .NUM_LOCAL    (4),
    .MTVEC_RESET  (32'h0001_0000),
    .CNT_EN_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr        (bus),
    .retire     (retire),
    .mret       (mret),
    .wfi        (wfi),
    .exe_pc     (exe_pc),
    .irq_accept (irq_accept),
    .irq_ext    (irq_ext),
    .irq_timer  (irq_timer),
    .irq_local  (irq_local),
    .trap_taken (trap_taken),
    .trap_pc    (trap_pc),
    .mret_pc    (mret_pc),
    .wfi_stall  (wfi_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    chk(tag, bus.csr_rdata, exp);
  endtask

  task automatic csr_op(input logic [2:0] o, input logic [11:0] a,
                        input logic [31:0] d, input logic z);
    bus.csr_req      = 1'b1;
    bus.csr_op       = o;
    bus.csr_addr     = a;
    bus.csr_wdata    = d;
    bus.csr_src_zero = z;
    @(posedge clk);
    #1;
    bus.csr_req      = 1'b0;
    bus.csr_src_zero = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    retire = 0; mret = 0; wfi = 0; irq_accept = 0;
    irq_ext = 0; irq_timer = 0; irq_local = '0; exe_pc = '0;
    bus.csr_req = 0; bus.csr_op = '0; bus.csr_addr = '0;
    bus.csr_src_zero = 0; bus.csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset values, read while reset is held
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mie",     12'h304, 32'h0);
    rd("rst_mip",     12'h344, 32'h0);
    rd("rst_mtvec",   12'h305, 32'h0001_0000);
    rd("rst_mepc",    12'h341, 32'h0);
    rd("rst_mcause",  12'h342, 32'h0);
    rd("rst_minh",    12'h320, 32'h0);
    rd("rst_mcycle",  12'hB00, 32'h0);
    rd("rst_mcycleh", 12'hB80, 32'h0);
    rd("rst_minstr",  12'hB02, 32'h0);
    rd("rst_minstrh", 12'hB82, 32'h0);
    rd("rst_cycle",   12'hC00, 32'h0);
    rd("rst_instret", 12'hC02, 32'h0);
    chk("rst_trap", {31'd0, trap_taken}, 32'd0);
    chk("rst_stall", {31'd0, wfi_stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // timer trap, direct mode, with a colliding mepc write that must drop
    csr_op(3'b010, 12'h304, 32'h880, 1'b0);
    csr_op(3'b110, 12'h300, 32'h8, 1'b0);
    rd("en_mstatus", 12'h300, 32'h0000_1808);
    irq_timer = 1; irq_accept = 1; exe_pc = 32'h200;
    bus.csr_req = 1; bus.csr_op = 3'b001;
    bus.csr_addr = 12'h341; bus.csr_wdata = 32'h999;
    #1;
    chk("t1_taken", {31'd0, trap_taken}, 32'd1);
    chk("t1_pc", trap_pc, 32'h0001_0000);
    @(posedge clk);
    #1;
    irq_timer = 0; irq_accept = 0; bus.csr_req = 0;
    #1;
    chk("t1_taken_off", {31'd0, trap_taken}, 32'd0);
    rd("t1_mepc",    12'h341, 32'h200);
    rd("t1_mcause",  12'h342, 32'h8000_0007);
    rd("t1_mstatus", 12'h300, 32'h0000_1880);

    // mtvec MODE handling, vectored trap with three sources pending
    csr_op(3'b001, 12'h305, 32'h0002_0002, 1'b0);
    rd("tv_mode1x", 12'h305, 32'h0002_0000);
    csr_op(3'b001, 12'h305, 32'h0001_0001, 1'b0);
    rd("tv_vec", 12'h305, 32'h0001_0001);
    csr_op(3'b110, 12'h300, 32'h8, 1'b0);
    irq_ext = 1; irq_timer = 1; irq_local = 4'b0100;
    irq_accept = 1; exe_pc = 32'h300;
    #1;
    chk("t2_taken", {31'd0, trap_taken}, 32'd1);
    chk("t2_pc", trap_pc, 32'h0001_002C);
    @(posedge clk);
    #1;
    irq_ext = 0; irq_timer = 0; irq_local = '0; irq_accept = 0;
    rd("t2_mcause",  12'h342, 32'h8000_000B);
    rd("t2_mstatus", 12'h300, 32'h0000_1880);
    mret = 1;
    #1;
    chk("mret_pc", mret_pc, 32'h300);
    @(posedge clk);
    #1;
    mret = 0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    irq_local = 4'b1000;
    rd("mip_local3", 12'h344, 32'h0008_0000);
    irq_local = '0;

    // WFI with MIE clear: stall until a local line is pending
    csr_op(3'b111, 12'h300, 32'h8, 1'b0);
    csr_op(3'b010, 12'h304, 32'h1_0000, 1'b0);
    rd("wfi_mie", 12'h304, 32'h0001_0880);
    wfi = 1;
    @(posedge clk);
    #1;
    wfi = 0;
    for (int k = 0; k < 5; k++) begin
      chk("wfi_high", {31'd0, wfi_stall}, 32'd1);
      if (k == 4) irq_local = 4'b0001;
      #1;
      chk("wfi_notrap", {31'd0, trap_taken}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("wfi_low", {31'd0, wfi_stall}, 32'd0);
    wfi = 1;
    @(posedge clk);
    #1;
    wfi = 0;
    chk("wfi_pend_nostall", {31'd0, wfi_stall}, 32'd0);
    irq_local = '0;
    wfi = 1;
    @(posedge clk);
    #1;
    wfi = 0;
    chk("wfi_again", {31'd0, wfi_stall}, 32'd1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("wfi_rst_drop", {31'd0, wfi_stall}, 32'd0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);

    // 64-bit cycle wrap, then inhibit
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    csr_op(3'b001, 12'hB80, 32'hFFFF_FFFF, 1'b0);
    rd("cy_ones", 12'hB00, 32'hFFFF_FFFF);
    @(posedge clk);
    rd("cy_wrap_lo", 12'hB00, 32'h0);
    @(posedge clk);
    rd("cy_wrap_hi", 12'hB80, 32'h0);
    csr_op(3'b101, 12'h320, 32'h1, 1'b0);
    rd("minh", 12'h320, 32'h1);
    csr_op(3'b001, 12'hB00, 32'h1234, 1'b0);
    rd("cy_frozen0", 12'hB00, 32'h1234);
    repeat (2) @(posedge clk);
    rd("cy_frozen1", 12'hB00, 32'h1234);

    // instret: write suppresses the coincident retire, then 3 retires
    retire = 1;
    csr_op(3'b001, 12'hB02, 32'h5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    retire = 0;
    rd("instret_lo", 12'hC02, 32'h8);
    rd("instret_hi", 12'hC82, 32'h0);

    // zero-source clear, read-only shadow and unimplemented address
    csr_op(3'b110, 12'h300, 32'h8, 1'b0);
    csr_op(3'b011, 12'h300, 32'h8, 1'b1);
    rd("rc_x0", 12'h300, 32'h0000_1808);
    bus.csr_req = 1; bus.csr_op = 3'b001;
    bus.csr_addr = 12'hC00; bus.csr_wdata = 32'hDEAD;
    #1;
    chk("ro_rdata", bus.csr_rdata, 32'h1234);
    @(posedge clk);
    #1;
    bus.csr_req = 0;
    rd("ro_kept", 12'hC00, 32'h1234);
    csr_op(3'b001, 12'h7C0, 32'hFFFF_FFFF, 1'b0);
    rd("unimpl", 12'h7C0, 32'h0);
    csr_op(3'b001, 12'h344, 32'hFFFF_FFFF, 1'b0);
    rd("mip_ro", 12'h344, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
